// File: rtl/alu_bit_sequencer.sv
// ---------------------------------------------------------------------------
// alu_bit_sequencer
//
// Upstream operand sequencer for a bit-serial 1-bit ALU. A parallel operand
// pair and op code are accepted over a valid/ready handshake. The operands
// are streamed LSB-first to the ALU one bit per clock. The ALU's serial
// result bits are collected into a parallel word, which is then offered
// downstream over a second valid/ready handshake. The op code is passed
// through to the ALU unchanged and is held for the whole word.
//
// Parameters:
//   WIDTH    operand/result word width in bits (>= 2)
//   ALU_LAT  clocks from the ALU sampling A/B/ALU_Sel to ALU_out valid (>= 1)
//
// Ports:
//   clk        rising-edge clock, shared with the ALU
//   rst        synchronous active-high reset
//   in_valid   upstream offers an operand word
//   in_ready   sequencer can accept a word (IDLE only)
//   op_a/op_b  operand words
//   op_sel     operation code, forwarded as ALU_Sel
//   A/B        serial operand bits to the ALU
//   ALU_Sel    op select to the ALU
//   ALU_out    serial result bit from the ALU
//   res_valid  assembled result word available
//   res_ready  consumer takes the result
//   result     assembled result, bit0 = first ALU_out captured
//   res_sel    op code that produced the result
// ---------------------------------------------------------------------------
module alu_bit_sequencer #(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       op_sel,
  output logic             A,
  output logic             B,
  output logic [1:0]       ALU_Sel,
  input  logic             ALU_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       res_sel
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_WIDTH = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Registered state and outputs
  state_t             r_state;
  logic [CW-1:0]      r_issueCnt;
  logic [CW-1:0]      r_capCnt;
  logic [WIDTH-1:0]   r_shA;
  logic [WIDTH-1:0]   r_shB;
  logic               r_A;
  logic               r_B;
  logic [1:0]         r_sel;
  logic               r_inReady;
  logic               r_resValid;
  logic [WIDTH-1:0]   r_result;
  logic [1:0]         r_resSel;
  logic               r_bitValid;
  logic [ALU_LAT-1:0] r_capPipe;

  // Next-state values
  state_t             w_stateNext;
  logic [CW-1:0]      w_issueCntNext;
  logic [CW-1:0]      w_capCntNext;
  logic [WIDTH-1:0]   w_shANext;
  logic [WIDTH-1:0]   w_shBNext;
  logic               w_ANext;
  logic               w_BNext;
  logic [1:0]         w_selNext;
  logic               w_inReadyNext;
  logic               w_resValidNext;
  logic [WIDTH-1:0]   w_resultNext;
  logic [1:0]         w_resSelNext;
  logic               w_bitValidNext;
  logic [ALU_LAT:0]   w_pipeExt;
  logic               w_capNow;
  logic               w_accept;

  // r_bitValid marks a cycle in which a real operand bit sits on A/B.
  // Delaying that flag by ALU_LAT stages lines it up with the ALU_out bit
  // that belongs to it, so the tail of the pipe is the capture strobe.
  // Clearing the pipe on reset is what makes stale ALU_out bits harmless.
  assign w_pipeExt = {r_capPipe, r_bitValid};
  assign w_capNow  = r_capPipe[ALU_LAT-1];
  assign w_accept  = in_valid && in_ready;

  // in_ready is additionally masked by rst so an offer made while reset is
  // asserted never looks accepted from the upstream side.
  assign in_ready  = r_inReady && !rst;
  assign A         = r_A;
  assign B         = r_B;
  assign ALU_Sel   = r_sel;
  assign res_valid = r_resValid;
  assign result    = r_result;
  assign res_sel   = r_resSel;

  // Next-state and next-output logic. Issue (driving A/B) is handled per
  // state; capture runs independently of state because with a short ALU
  // latency the first result bits arrive while still in SHIFT.
  always_comb begin
    w_stateNext    = r_state;
    w_issueCntNext = r_issueCnt;
    w_capCntNext   = r_capCnt;
    w_shANext      = r_shA;
    w_shBNext      = r_shB;
    w_ANext        = r_A;
    w_BNext        = r_B;
    w_selNext      = r_sel;
    w_resValidNext = r_resValid;
    w_resultNext   = r_result;
    w_resSelNext   = r_resSel;
    w_bitValidNext = r_bitValid;

    case (r_state)
      IDLE: begin
        w_ANext = 1'b0;
        w_BNext = 1'b0;
        if (w_accept) begin
          // Bit 0 goes straight onto the wire at the accept edge; the
          // remaining bits are kept in shift registers.
          w_stateNext    = SHIFT;
          w_ANext        = op_a[0];
          w_BNext        = op_b[0];
          w_selNext      = op_sel;
          w_shANext      = op_a >> 1;
          w_shBNext      = op_b >> 1;
          w_issueCntNext = CNT_ONE;
          w_capCntNext   = '0;
          w_bitValidNext = 1'b1;
        end
      end

      SHIFT: begin
        if (r_issueCnt < CNT_WIDTH) begin
          w_ANext        = r_shA[0];
          w_BNext        = r_shB[0];
          w_shANext      = r_shA >> 1;
          w_shBNext      = r_shB >> 1;
          w_issueCntNext = r_issueCnt + CNT_ONE;
        end else begin
          w_ANext        = 1'b0;
          w_BNext        = 1'b0;
          w_bitValidNext = 1'b0;
          w_stateNext    = DRAIN;
        end
      end

      DRAIN: begin
        w_ANext = 1'b0;
        w_BNext = 1'b0;
      end

      DONE: begin
        w_ANext = 1'b0;
        w_BNext = 1'b0;
        if (res_ready) begin
          w_resValidNext = 1'b0;
          w_stateNext    = IDLE;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase

    // Capture shifts in at the MSB, so after WIDTH captures the first bit
    // has walked down to bit 0. The last capture overrides the issue-side
    // transition, which covers the case where it lands on the final issue
    // edge and the machine goes straight to DONE.
    if (w_capNow && (r_capCnt < CNT_WIDTH)) begin
      w_resultNext = {ALU_out, r_result[WIDTH-1:1]};
      w_capCntNext = r_capCnt + CNT_ONE;
      if (r_capCnt == CNT_LAST) begin
        w_stateNext    = DONE;
        w_resValidNext = 1'b1;
        w_resSelNext   = r_sel;
        w_bitValidNext = 1'b0;
      end
    end

    w_inReadyNext = (w_stateNext == IDLE);
  end

  // State and output registers. Reset wins over everything and drops any
  // word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_issueCnt <= '0;
      r_capCnt   <= '0;
      r_shA      <= '0;
      r_shB      <= '0;
      r_A        <= 1'b0;
      r_B        <= 1'b0;
      r_sel      <= 2'b00;
      r_inReady  <= 1'b0;
      r_resValid <= 1'b0;
      r_result   <= '0;
      r_resSel   <= 2'b00;
      r_bitValid <= 1'b0;
      r_capPipe  <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_issueCnt <= w_issueCntNext;
      r_capCnt   <= w_capCntNext;
      r_shA      <= w_shANext;
      r_shB      <= w_shBNext;
      r_A        <= w_ANext;
      r_B        <= w_BNext;
      r_sel      <= w_selNext;
      r_inReady  <= w_inReadyNext;
      r_resValid <= w_resValidNext;
      r_result   <= w_resultNext;
      r_resSel   <= w_resSelNext;
      r_bitValid <= w_bitValidNext;
      r_capPipe  <= w_pipeExt[ALU_LAT-1:0];
    end
  end

endmodule

// File: tb/tb_alu_bit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_bit_sequencer
//
// Two sequencer instances share one clock and reset: an 8-bit one paired
// with a one-stage stub ALU and a 16-bit one paired with a two-stage stub
// ALU. Expected results come from whole-word operations on the operands,
// and expected serial bits come from indexing the operand words directly.
// ---------------------------------------------------------------------------
module tb_alu_bit_sequencer;

  logic clk;
  logic rst;

  // 8-bit instance
  logic        inValid8, inReady8;
  logic [7:0]  opA8, opB8;
  logic [1:0]  opSel8;
  logic        a8, b8;
  logic [1:0]  sel8;
  logic        aluOut8;
  logic        resValid8, resReady8;
  logic [7:0]  result8;
  logic [1:0]  resSel8;

  // 16-bit instance
  logic        inValid16, inReady16;
  logic [15:0] opA16, opB16;
  logic [1:0]  opSel16;
  logic        a16, b16;
  logic [1:0]  sel16;
  logic        aluStage16, aluOut16;
  logic        resValid16, resReady16;
  logic [15:0] result16;
  logic [1:0]  resSel16;

  int total = 0;
  int bad   = 0;

  alu_bit_sequencer #(.WIDTH(8), .ALU_LAT(1)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(inValid8), .in_ready(inReady8),
    .op_a(opA8), .op_b(opB8), .op_sel(opSel8),
    .A(a8), .B(b8), .ALU_Sel(sel8), .ALU_out(aluOut8),
    .res_valid(resValid8), .res_ready(resReady8),
    .result(result8), .res_sel(resSel8)
  );

  alu_bit_sequencer #(.WIDTH(16), .ALU_LAT(2)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(inValid16), .in_ready(inReady16),
    .op_a(opA16), .op_b(opB16), .op_sel(opSel16),
    .A(a16), .B(b16), .ALU_Sel(sel16), .ALU_out(aluOut16),
    .res_valid(resValid16), .res_ready(resReady16),
    .result(result16), .res_sel(resSel16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-bit ALU behaviour used by the stub ALUs
  function automatic logic aluBit(input logic a, input logic b, input logic [1:0] s);
    case (s)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Reference model: whole-word result of the operation
  function automatic logic [15:0] wordModel(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] s);
    case (s)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Stub ALUs: one register stage (8-bit pair) and two stages (16-bit pair)
  always @(posedge clk) aluOut8 <= aluBit(a8, b8, sel8);

  always @(posedge clk) begin
    aluStage16 <= aluBit(a16, b16, sel16);
    aluOut16   <= aluStage16;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit word end to end: accept, serial bit checks, latency, result,
  // hold with res_ready low, then handshake. With disturb set, in_valid and
  // the operand inputs are changed in the middle of SHIFT.
  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                                input int hold, input bit disturb);
    logic [7:0] expRes;
    int cnt;
    int waitCnt;
    expRes  = wordModel({8'h00, a}, {8'h00, b}, s);
    waitCnt = 0;
    while (!inReady8 && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    checkOutput("inReady8 before accept", inReady8, 1);
    inValid8 = 1'b1;
    opA8     = a;
    opB8     = b;
    opSel8   = s;
    tick();
    inValid8 = 1'b0;
    cnt      = 0;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("A8 bit%0d", i), a8, a[i]);
      checkOutput($sformatf("B8 bit%0d", i), b8, b[i]);
      checkOutput("ALU_Sel8 in SHIFT", sel8, s);
      checkOutput("inReady8 in SHIFT", inReady8, 0);
      if (disturb && i >= 3) begin
        inValid8 = ~inValid8;
        opA8     = ~opA8;
        opSel8   = opSel8 + 2'd1;
      end
      tick();
      cnt++;
    end
    inValid8 = 1'b0;
    while (!resValid8 && cnt < 40) begin
      tick();
      cnt++;
    end
    checkOutput("latency8", cnt, 9);
    checkOutput("result8", result8, expRes);
    checkOutput("resSel8", resSel8, s);
    for (int h = 0; h < hold; h++) begin
      tick();
      checkOutput("result8 held", result8, expRes);
      checkOutput("resValid8 held", resValid8, 1);
      checkOutput("inReady8 in DONE", inReady8, 0);
    end
    resReady8 = 1'b1;
    tick();
    resReady8 = 1'b0;
    checkOutput("resValid8 after handshake", resValid8, 0);
    checkOutput("inReady8 after handshake", inReady8, 1);
  endtask

  // One 16-bit word through the two-stage ALU pair
  task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
    logic [15:0] expRes;
    int cnt;
    int waitCnt;
    expRes  = wordModel(a, b, s);
    waitCnt = 0;
    while (!inReady16 && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    checkOutput("inReady16 before accept", inReady16, 1);
    inValid16 = 1'b1;
    opA16     = a;
    opB16     = b;
    opSel16   = s;
    tick();
    inValid16 = 1'b0;
    cnt       = 0;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("A16 bit%0d", i), a16, a[i]);
      tick();
      cnt++;
    end
    while (!resValid16 && cnt < 60) begin
      tick();
      cnt++;
    end
    checkOutput("latency16", cnt, 18);
    checkOutput("result16", result16, expRes);
    checkOutput("resSel16", resSel16, s);
    resReady16 = 1'b1;
    tick();
    resReady16 = 1'b0;
    checkOutput("resValid16 after handshake", resValid16, 0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [1:0] rs;
    logic [7:0] f0, c3c;
    rst        = 1'b1;
    inValid8   = 1'b0; opA8 = '0; opB8 = '0; opSel8 = '0; resReady8 = 1'b0;
    inValid16  = 1'b0; opA16 = '0; opB16 = '0; opSel16 = '0; resReady16 = 1'b0;

    // Reset held two cycles, then released
    tick();
    tick();
    checkOutput("inReady8 during reset", inReady8, 0);
    rst = 1'b0;
    tick();
    checkOutput("reset inReady8", inReady8, 1);
    checkOutput("reset resValid8", resValid8, 0);
    checkOutput("reset A8", a8, 0);
    checkOutput("reset B8", b8, 0);
    checkOutput("reset ALU_Sel8", sel8, 0);
    checkOutput("reset result8", result8, 0);
    checkOutput("reset inReady16", inReady16, 1);

    // Directed XOR word
    applyStimulus8(8'hA5, 8'h0F, 2'b10, 0, 1'b0);

    // All four ops with a 5-cycle hold on each result
    f0  = 8'hF0;
    c3c = 8'h3C;
    for (int op = 0; op < 4; op++) applyStimulus8(f0, c3c, 2'(op), 5, 1'b0);

    // Input disturbance mid-SHIFT, then back-to-back words
    applyStimulus8(8'h5A, 8'hC3, 2'b01, 1, 1'b1);
    applyStimulus8(8'h0F, 8'hFF, 2'b00, 0, 1'b0);
    applyStimulus8(8'h81, 8'h18, 2'b11, 0, 1'b0);

    // Randomized words
    for (int k = 0; k < 8; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 2'($urandom_range(0, 3));
      applyStimulus8(ra, rb, rs, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset in the 4th SHIFT cycle
    inValid8 = 1'b1;
    opA8     = 8'h3C;
    opB8     = 8'hA7;
    opSel8   = 2'b11;
    tick();
    inValid8 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("A8 before mid reset", a8, 1'b1);
    rst = 1'b1;
    tick();
    checkOutput("mid reset A8", a8, 0);
    checkOutput("mid reset B8", b8, 0);
    checkOutput("mid reset ALU_Sel8", sel8, 0);
    checkOutput("mid reset resValid8", resValid8, 0);
    checkOutput("mid reset result8", result8, 0);
    checkOutput("mid reset resSel8", resSel8, 0);
    checkOutput("mid reset inReady8", inReady8, 0);
    rst = 1'b0;
    tick();
    checkOutput("inReady8 after mid reset", inReady8, 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput("resValid8 stays low after reset", resValid8, 0);
    end
    applyStimulus8(8'hFF, 8'h81, 2'b00, 0, 1'b0);

    // Wider instance with two-cycle ALU latency
    applyStimulus16(16'h1234, 16'h8001, 2'b01);
    for (int k = 0; k < 3; k++) begin
      applyStimulus16(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_bit_sequencer.md
Name: alu_bit_sequencer

Overview:
Upstream operand sequencer for the bit-serial 1-bit ALU. It accepts a parallel WIDTH-bit operand pair and a 2-bit op code over a valid/ready handshake. It streams the operands LSB-first into the ALU's A/B/ALU_Sel inputs, one bit per clk, collects the registered ALU_out bits back into a parallel result word, and presents that word over a second valid/ready handshake. The sequencer does not interpret the operation: ALU_Sel is held constant for the whole word.

Parameters:
WIDTH, 8, operand/result word width in bits (>=2)
ALU_LAT, 1, clk cycles from ALU sampling A/B/ALU_Sel to ALU_out valid (>=1)

Ports:
clk  input  1  rising-edge clock, shared with ALU
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand word offered
in_ready  output  1  sequencer can accept a word
op_a  input  WIDTH  operand A word
op_b  input  WIDTH  operand B word
op_sel  input  2  operation code, forwarded as ALU_Sel
A  output  1  serial A bit to ALU
B  output  1  serial B bit to ALU
ALU_Sel  output  2  op select to ALU
ALU_out  input  1  serial result bit from ALU
res_valid  output  1  result word available
res_ready  input  1  consumer takes result
result  output  WIDTH  assembled result word, bit0 = first ALU_out captured
res_sel  output  2  op code that produced result

Behaviour:
- States: IDLE, SHIFT, DRAIN, DONE. All state and outputs are registered on rising clk. rst is sampled only at the edge.
- Reset (any state, including mid-word): state=IDLE; issue_cnt and cap_cnt = 0; A=B=0; ALU_Sel=00; res_valid=0; result=0; res_sel=00. in_ready=0 while rst is high. The in-flight word is discarded and any ALU_out arriving afterwards is ignored.
- IDLE: in_ready=1; A=B=0. On in_valid&&in_ready at edge E0: latch op_a, op_b, op_sel; go to SHIFT. in_ready=0 in every other state, so there is no input buffering.
- SHIFT: between edges E(i) and E(i+1), for i=0..WIDTH-1, drive A=op_a[i], B=op_b[i], ALU_Sel=op_sel. Shift one bit per cycle. After WIDTH issue cycles go to DRAIN, or straight to DONE when the last capture coincides.
- Capture: the ALU_out produced for bit i is sampled at edge E(i+1+ALU_LAT) and written to result[i] (shift in at MSB, shift right). cap_cnt counts captures, range 0..WIDTH. ALU_out is never sampled outside the WIDTH capture slots.
- DRAIN: A=B=0, ALU_Sel held. Waits for the remaining ALU_LAT captures. When cap_cnt reaches WIDTH go to DONE.
- Latency: res_valid rises exactly WIDTH+ALU_LAT cycles after the accept edge E0 (9 cycles for defaults).
- DONE: res_valid=1; result and res_sel are stable until handshake. On res_valid&&res_ready: res_valid=0 and state=IDLE at that edge. Next accept is possible one cycle later. Back-to-back throughput is one word per WIDTH+ALU_LAT+2 cycles.
- res_ready held high before DONE has no effect. res_ready low holds DONE indefinitely, with result unchanged.
- in_valid during SHIFT/DRAIN/DONE is ignored, and the upstream must hold the word. op_a, op_b and op_sel changing after accept do not affect the word in flight.
- Counters are sized ceil(log2(WIDTH+1)) bits and never wrap within a word.

Test Plan:
(Bench pairs the DUT with a registered stub ALU, ALU_LAT=1: 00=AND, 01=OR, 10=XOR, 11=NAND; WIDTH=8.)
1. Reset: hold rst 2 cycles, then release -> next cycle in_ready=1, res_valid=0, A=B=0, ALU_Sel=00, result=0.
2. op_a=8'hA5, op_b=8'h0F, op_sel=10 accepted at E0 -> A sequence 1,0,1,0,0,1,0,1 on cycles 1..8; res_valid high at E9; result=8'hAA; res_sel=10.
3. Run all four ops on 8'hF0/8'h3C -> AND=8'h30, OR=8'hFC, XOR=8'hCC, NAND=8'hCF. Each result is held while res_ready=0 for 5 cycles, and in_ready=0 throughout.
4. Toggle in_valid and op_a mid-SHIFT -> no second accept, and the in-flight result is unchanged. Back-to-back words with res_ready=1 -> next accept exactly one cycle after the result handshake.
5. Assert rst at the 4th SHIFT cycle -> all outputs return to reset values at the next edge. A following word 8'hFF AND 8'h81 -> result=8'h81, with no corruption from stale bits.
6. Re-parameterise WIDTH=16, ALU_LAT=2: 16'h1234 OR 16'h8001 -> result=16'h9235, with res_valid exactly 18 cycles after accept.
